// File: rtl/barrel_pkg.sv
// barrel_pkg: slot states, girder table, ladder columns and screen limits shared by barrel_pool.
// The ladder column table is only consulted when BARREL_LADDER_DROP_EN is defined.
package barrel_pkg;

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_FALL   = 2'd1,
    S_ROLL_R = 2'd2,
    S_ROLL_L = 2'd3
  } slot_state_e;

  // Index 5 is the top girder, index 0 the bottom one.
  localparam logic [5:0][9:0] PLAT_Y      = {10'd130, 10'd190, 10'd250, 10'd310, 10'd370, 10'd430};
  localparam logic [5:0][9:0] PLAT_XSTART = {10'd30,  10'd80,  10'd30,  10'd80,  10'd30,  10'd30};
  localparam logic [5:0][9:0] PLAT_XEND   = {10'd560, 10'd610, 10'd560, 10'd610, 10'd560, 10'd610};
  localparam logic [5:0]      PLAT_DIR_R  = 6'b101010;
  localparam logic [5:0][9:0] LADDER_X    = {10'd300, 10'd200, 10'd400, 10'd250, 10'd350, 10'd0};

  localparam logic [9:0] SPAWN_X      = 10'd130;
  localparam logic [9:0] SPAWN_Y      = 10'd118;
  localparam logic [2:0] SPAWN_PIDX   = 3'd5;
  localparam logic [9:0] SCREEN_X_MAX = 10'd639;
  localparam logic [9:0] FLOOR_Y      = 10'd479;

endpackage

// File: rtl/barrel_slot.sv
// barrel_slot: one barrel's roll/fall FSM, centre position and animation phase.
// A slot only leaves IDLE on spawn_i; clear_i (restart while paused) empties it.
module barrel_slot
  import barrel_pkg::*;
#(
  parameter int X_STEP = 3,
  parameter int Y_STEP = 3,
  parameter int SIZE   = 12
) (
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic       pause_i,
  input  logic       clear_i,
  input  logic       spawn_i,
  input  logic       ladderGo_i,
  output logic [9:0] x_o,
  output logic [9:0] y_o,
  output logic       active_o,
  output logic       phase_o,
  output logic       activeNext_o
);

  localparam logic [9:0] XS = 10'(X_STEP);
  localparam logic [9:0] YS = 10'(Y_STEP);
  localparam logic [9:0] SZ = 10'(SIZE);

  slot_state_e state_q, state_d;
  logic [2:0]  pidx_q, pidx_d, pidxDn;
  logic [9:0]  x_q, x_d, y_q, y_d, ladderHi;
  logic [3:0]  anim_q, anim_d;
  logic        phase_q, phase_d, active_q, retire, ladderOk;

  // Every edge derives the next position from the current one; a landing snap replaces the step.
  always_comb begin
    state_d  = state_q;
    pidx_d   = pidx_q;
    x_d      = x_q;
    y_d      = y_q;
    anim_d   = anim_q;
    phase_d  = phase_q;
    retire   = 1'b0;
    pidxDn   = pidx_q - 3'd1;
    ladderHi = LADDER_X[pidx_q] + XS - 10'd1;
    ladderOk = ladderGo_i && (pidx_q != 3'd0);
    if (clear_i) begin
      retire = 1'b1;
    end else if (!pause_i) begin
      if (state_q == S_IDLE) begin
        if (spawn_i) begin
          state_d = S_ROLL_R;
          pidx_d  = SPAWN_PIDX;
          x_d     = SPAWN_X;
          y_d     = SPAWN_Y;
          anim_d  = 4'd0;
          phase_d = 1'b0;
        end
      end else begin
        if (anim_q == 4'd8) begin
          anim_d  = 4'd0;
          phase_d = ~phase_q;
        end else begin
          anim_d = anim_q + 4'd1;
        end
        case (state_q)
          S_ROLL_R: begin
            x_d = x_q + XS;
            if ((x_d > PLAT_XEND[pidx_q] + SZ) ||
                (ladderOk && x_d >= LADDER_X[pidx_q] && x_d <= ladderHi))
              state_d = S_FALL;
          end
          S_ROLL_L: begin
            x_d = x_q - XS;
            if ((x_d + SZ < PLAT_XSTART[pidx_q]) ||
                (ladderOk && x_d >= LADDER_X[pidx_q] && x_d <= ladderHi))
              state_d = S_FALL;
          end
          S_FALL: begin
            if (pidx_q != 3'd0) begin
              if (y_q + SZ + YS >= PLAT_Y[pidxDn]) begin
                y_d     = PLAT_Y[pidxDn] - SZ;
                pidx_d  = pidxDn;
                state_d = PLAT_DIR_R[pidxDn] ? S_ROLL_R : S_ROLL_L;
              end else begin
                y_d = y_q + YS;
              end
            end else begin
              y_d = y_q + YS;
              if (y_d + SZ >= FLOOR_Y) retire = 1'b1;
            end
          end
          default: ;
        endcase
        if (x_d < SZ || x_d + SZ > SCREEN_X_MAX) retire = 1'b1;
      end
    end
    if (retire) begin
      state_d = S_IDLE;
      pidx_d  = 3'd0;
      x_d     = 10'd0;
      y_d     = 10'd0;
      anim_d  = 4'd0;
      phase_d = 1'b0;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q  <= S_IDLE;
      pidx_q   <= 3'd0;
      x_q      <= 10'd0;
      y_q      <= 10'd0;
      anim_q   <= 4'd0;
      phase_q  <= 1'b0;
      active_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      pidx_q   <= pidx_d;
      x_q      <= x_d;
      y_q      <= y_d;
      anim_q   <= anim_d;
      phase_q  <= phase_d;
      active_q <= (state_d != S_IDLE);
    end
  end

  assign x_o          = x_q;
  assign y_o          = y_q;
  assign active_o     = active_q;
  assign phase_o      = phase_q;
  assign activeNext_o = (state_d != S_IDLE);

endmodule

// File: rtl/barrel_pool.sv
// barrel_pool: pool of barrel slots with a periodic spawner feeding the lowest idle slot.
// Defining BARREL_LADDER_DROP_EN adds an LFSR that lets barrels drop early down ladders.
module barrel_pool
  import barrel_pkg::*;
#(
  parameter int NUM_BARRELS = 4,
  parameter int START_DELAY = 0,
  parameter int SPAWN_GAP   = 90,
  parameter int X_STEP      = 3,
  parameter int Y_STEP      = 3,
  parameter int SIZE        = 12
) (
  input  logic                     frame_clk,
  input  logic                     Reset,
  input  logic                     pause,
  input  logic                     enter,
  output logic [NUM_BARRELS*10-1:0] BarrelX,
  output logic [NUM_BARRELS*10-1:0] BarrelY,
  output logic [NUM_BARRELS-1:0]   BarrelActive,
  output logic [NUM_BARRELS-1:0]   BarrelState,
  output logic [9:0]               BarrelS,
  output logic [3:0]               alive_count
);

  localparam logic [15:0] START_LD = 16'(START_DELAY);
  localparam logic [15:0] GAP_LD   = 16'(SPAWN_GAP - 1);

  logic [15:0]            timer_q, timer_d;
  logic [3:0]             alive_d;
  logic [NUM_BARRELS-1:0] spawnVec, activeNext;
  logic                   clear, spawnTick, found, ladderGo;

  assign clear     = pause && enter;
  assign spawnTick = !pause && (timer_q == 16'd0);
  assign BarrelS   = 10'(SIZE);

  // A slot retiring on this edge still reads active, so it cannot be picked until the next spawn.
  always_comb begin
    spawnVec = '0;
    found    = 1'b0;
    for (int i = 0; i < NUM_BARRELS; i++) begin
      if (!BarrelActive[i] && !found) begin
        spawnVec[i] = spawnTick;
        found       = 1'b1;
      end
    end
  end

  always_comb begin
    timer_d = timer_q;
    if (clear)          timer_d = START_LD;
    else if (spawnTick) timer_d = GAP_LD;
    else if (!pause)    timer_d = timer_q - 16'd1;
    alive_d = 4'd0;
    for (int i = 0; i < NUM_BARRELS; i++) alive_d = alive_d + {3'b000, activeNext[i]};
  end

  always_ff @(posedge frame_clk) begin
    if (Reset) begin
      timer_q     <= START_LD;
      alive_count <= 4'd0;
    end else begin
      timer_q     <= timer_d;
      alive_count <= alive_d;
    end
  end

`ifdef BARREL_LADDER_DROP_EN
  logic [7:0] lfsr_q, lfsr_d;

  // x^8+x^6+x^5+x^4+1, stepping only on unpaused frames.
  always_comb begin
    lfsr_d = lfsr_q;
    if (!pause) lfsr_d = {lfsr_q[6:0], lfsr_q[7] ^ lfsr_q[5] ^ lfsr_q[4] ^ lfsr_q[3]};
  end

  always_ff @(posedge frame_clk) begin
    if (Reset) lfsr_q <= 8'hA5;
    else       lfsr_q <= lfsr_d;
  end

  assign ladderGo = (lfsr_q[1:0] == 2'b00);
`else
  assign ladderGo = 1'b0;
`endif

  for (genvar g = 0; g < NUM_BARRELS; g++) begin : gSlot
    barrel_slot #(
      .X_STEP(X_STEP),
      .Y_STEP(Y_STEP),
      .SIZE  (SIZE)
    ) u_slot (
      .clk_i       (frame_clk),
      .rst_i       (Reset),
      .pause_i     (pause),
      .clear_i     (clear),
      .spawn_i     (spawnVec[g]),
      .ladderGo_i  (ladderGo),
      .x_o         (BarrelX[g*10 +: 10]),
      .y_o         (BarrelY[g*10 +: 10]),
      .active_o    (BarrelActive[g]),
      .phase_o     (BarrelState[g]),
      .activeNext_o(activeNext[g])
    );
  end

endmodule
